// File: rtl/instruction_sequencer_pkg.sv
// Shared constants for the instruction sequencer: instruction width,
// FSM state encoding and the saturating issue-counter helper.
package instruction_sequencer_pkg;

   localparam int INSTRUCTION_WIDTH = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_ACK   = 3'd3,
      S_EXEC  = 3'd4,
      S_DONE  = 3'd5
   } seq_state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/instruction_sequencer_mem.sv
// seq_program_mem: DEPTH x WIDTH program store, one synchronous write
// port (out-of-range writes dropped), one combinational read port.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i -> rdata_o.
module seq_program_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             in_range;

   if (DEPTH == (1 << AW)) begin : g_full
      assign in_range = 1'b1;
   end else begin : g_part
      assign in_range = ({1'b0, waddr_i} < DEPTH_W);
   end

   always_ff @(posedge clk_i) begin
      if (we_i && in_range) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: issues a loaded program word-by-word to a core,
// following redirects, with abort/error/done status. Ports: clk, reset
// (async active-low), load_*, prog_len, run, abort, core_busy, redirect_*,
// instr_out/instr_start, pc, running, done, error; issue_count only when
// SEQ_ISSUE_COUNT_EN is defined.
module instruction_sequencer
   import instruction_sequencer_pkg::*;
#(
   parameter int INSTR_WIDTH = INSTRUCTION_WIDTH,
   parameter int DEPTH       = 16,
   parameter int AW          = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_en,
   input  logic [AW-1:0]          load_addr,
   input  logic [INSTR_WIDTH-1:0] load_data,
   input  logic [AW:0]            prog_len,
   input  logic                   run,
   input  logic                   abort,
   input  logic                   core_busy,
   input  logic                   redirect_valid,
   input  logic [AW-1:0]          redirect_addr,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic                   instr_start,
   output logic [AW-1:0]          pc,
   output logic                   running,
   output logic                   done,
   output logic                   error
`ifdef SEQ_ISSUE_COUNT_EN
   ,output logic [31:0]           issue_count
`endif
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   seq_state_e             state_q, state_d;
   logic [AW-1:0]          pc_q, pc_d;
   logic [AW:0]            len_q, len_d;
   logic                   err_q, err_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic                   rv_q, rv_d;
   logic [AW-1:0]          ra_q, ra_d;

   logic [INSTR_WIDTH-1:0] mem_rdata;
   logic                   run_ok;
   logic                   rhit;
   logic [AW-1:0]          rtgt;
   logic [AW:0]            next_pc;

   seq_program_mem #(
      .WIDTH (INSTR_WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (load_en && (state_q == S_IDLE)),
      .waddr_i (load_addr),
      .wdata_i (load_data),
      .raddr_i (pc_q),
      .rdata_o (mem_rdata)
   );

   assign run_ok = run && (prog_len != '0)
                   && (prog_len <= DEPTH_W);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      len_d   = len_q;
      err_d   = err_q;
      instr_d = instr_q;
      // A redirect arriving in the same cycle as the busy drop still wins.
      rhit    = rv_q;
      rtgt    = ra_q;
      if ((state_q == S_ACK || state_q == S_EXEC)
          && redirect_valid) begin
         rhit = 1'b1;
         rtgt = redirect_addr;
      end
      rv_d    = rhit;
      ra_d    = rtgt;
      // One extra bit so pc = DEPTH-1 plus one does not wrap to zero.
      next_pc = rhit ? {1'b0, rtgt}
                     : {1'b0, pc_q} + (AW+1)'(1);

      unique case (state_q)
         S_IDLE: begin
            if (run) begin
               if (prog_len == '0) begin
                  state_d = S_DONE;
               end else if (!run_ok) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  len_d   = prog_len;
                  pc_d    = '0;
                  err_d   = 1'b0;
                  state_d = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (!core_busy) begin
               instr_d = mem_rdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            rv_d    = 1'b0;
            state_d = S_ACK;
         end
         S_ACK: state_d = S_EXEC;
         S_EXEC: begin
            if (!core_busy) begin
               pc_d = next_pc[AW-1:0];
               if (rhit && ({1'b0, rtgt} >= len_q)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (next_pc >= len_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         rv_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
         instr_q <= '0;
         rv_q    <= 1'b0;
         ra_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
         err_q   <= err_d;
         instr_q <= instr_d;
         rv_q    <= rv_d;
         ra_q    <= ra_d;
      end
   end

   assign instr_out   = instr_q;
   assign instr_start = (state_q == S_ISSUE);
   assign done        = (state_q == S_DONE);
   assign running     = (state_q != S_IDLE);
   assign pc          = pc_q;
   assign error       = err_q;

`ifdef SEQ_ISSUE_COUNT_EN
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_IDLE && run_ok) begin
         cnt_d = '0;
      end else if (state_q == S_ISSUE) begin
         cnt_d = sat_inc32(cnt_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign issue_count = cnt_q;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: directed programs, a
// small core model driving busy/redirect, and a monitor checking issues.
module tb_instruction_sequencer;

   localparam int W  = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [W-1:0]  load_data;
   logic [AW:0]   prog_len;
   logic          run, abort, core_busy;
   logic          redirect_valid;
   logic [AW-1:0] redirect_addr;
   logic [W-1:0]  instr_out;
   logic          instr_start;
   logic [AW-1:0] pc;
   logic          running, done, error;
`ifdef SEQ_ISSUE_COUNT_EN
   logic [31:0]   issue_count;
`endif

   instruction_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .prog_len       (prog_len),
      .run            (run),
      .abort          (abort),
      .core_busy      (core_busy),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .instr_out      (instr_out),
      .instr_start    (instr_start),
      .pc             (pc),
      .running        (running),
      .done           (done),
      .error          (error)
`ifdef SEQ_ISSUE_COUNT_EN
      ,.issue_count   (issue_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [W-1:0] exp_instr [$];
   logic         exp_done  [$];
   int           start_log [$];
   int           done_log  [$];

   int           busy_len  = 0;
   bit           redir_arm = 0;
   logic [W-1:0] redir_word;
   logic [AW-1:0] redir_tgt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every issued word and done pulse is matched in order.
   always @(negedge clk) begin
      if (instr_start) begin
         start_log.push_back(cyc);
         if (exp_instr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got %0h expected none",
                     instr_out);
         end else begin
            chk("instr_out", instr_out, exp_instr.pop_front());
         end
      end
      if (done) begin
         done_log.push_back(cyc);
         if (exp_done.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got 1 expected 0");
         end else begin
            chk("done_error", error, exp_done.pop_front());
         end
      end
   end

   // Core model: busy for busy_len cycles after each start, optional
   // one-cycle redirect in the ACK cycle.
   initial begin
      core_busy      = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      forever begin
         @(negedge clk);
         if (instr_start) begin
            automatic bit hit = redir_arm && (instr_out == redir_word);
            @(posedge clk);
            #1;
            core_busy = (busy_len != 0);
            if (hit) begin
               redirect_valid = 1'b1;
               redirect_addr  = redir_tgt;
               redir_arm      = 0;
            end
            if (busy_len == 0) begin
               @(posedge clk);
               #1 redirect_valid = 1'b0;
            end
            for (int k = 0; k < busy_len; k++) begin
               @(posedge clk);
               #1;
               redirect_valid = 1'b0;
               if (k == busy_len - 1) core_busy = 1'b0;
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input logic [W-1:0] d);
      load_en   = 1'b1;
      load_addr = AW'(a);
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   int run_cyc;

   task automatic start(input int len);
      prog_len = (AW+1)'(len);
      run      = 1'b1;
      run_cyc  = cyc;
      tick();
      run      = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!running) return;
      end
      checks++;
      errors++;
      $display("FAIL %s_timeout: got running expected idle", name);
   endtask

   task automatic wait_word(input logic [W-1:0] w);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (instr_start && instr_out == w) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_word_timeout: got none expected %0h", w);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_instr_out"}, instr_out, 0);
      chk({tag, "_start"}, instr_start, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_running"}, running, 0);
      chk({tag, "_pc"}, pc, 0);
   endtask

   initial begin
      reset     = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      prog_len  = '0;
      run       = 1'b0;
      abort     = 1'b0;
      #2;
      chk_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Four-word program, busy three cycles per instruction.
      for (int i = 0; i < 4; i++) load(i, W'(8'h11 * (i + 1)));
      busy_len = 3;
      exp_instr.push_back(32'h11);
      exp_instr.push_back(32'h22);
      exp_instr.push_back(32'h33);
      exp_instr.push_back(32'h44);
      exp_done.push_back(1'b0);
      start(4);
      wait_idle("s1");
      chk("s1_error", error, 0);
`ifdef SEQ_ISSUE_COUNT_EN
      chk("s1_issue_count", issue_count, 4);
`endif

      // Busy never high: timing of the two issues and the done pulse.
      busy_len = 0;
      start_log.delete();
      done_log.delete();
      exp_instr.push_back(32'h11);
      exp_instr.push_back(32'h22);
      exp_done.push_back(1'b0);
      start(2);
      load(1, 32'hEE);
      wait_idle("s2");
      chk("s2_nstarts", start_log.size(), 2);
      chk("s2_start0_cyc", start_log[0] - run_cyc, 2);
      chk("s2_start1_cyc", start_log[1] - run_cyc, 6);
      chk("s2_done_cyc", done_log[0] - run_cyc, 9);

      // Zero-length program completes at once without error.
      exp_done.push_back(1'b0);
      start(0);
      wait_idle("len0");

      // Redirect to 5 while pc=1 executes.
      for (int i = 4; i < 8; i++) load(i, W'(8'h11 * (i + 1)));
      busy_len   = 1;
      redir_word = 32'h22;
      redir_tgt  = 4'd5;
      redir_arm  = 1;
      exp_instr.push_back(32'h11);
      exp_instr.push_back(32'h22);
      exp_instr.push_back(32'h66);
      exp_instr.push_back(32'h77);
      exp_instr.push_back(32'h88);
      exp_done.push_back(1'b0);
      start(8);
      wait_idle("s3");

      // Redirect beyond prog_len ends the program with error.
      redir_word = 32'h22;
      redir_tgt  = 4'd9;
      redir_arm  = 1;
      exp_instr.push_back(32'h11);
      exp_instr.push_back(32'h22);
      exp_done.push_back(1'b1);
      start(4);
      wait_idle("s4");
      repeat (3) @(negedge clk);
      chk("s4_err_sticky", error, 1);
      busy_len = 0;
      exp_instr.push_back(32'h11);
      exp_done.push_back(1'b0);
      start(1);
      chk("s4_err_cleared", error, 0);
      wait_idle("s4b");

      // prog_len above DEPTH is rejected with error.
      exp_done.push_back(1'b1);
      start(17);
      wait_idle("len17");
      repeat (2) @(negedge clk);
      chk("len17_err", error, 1);

      // Abort while pc=2 executes.
      busy_len = 3;
      exp_instr.push_back(32'h11);
      exp_instr.push_back(32'h22);
      exp_instr.push_back(32'h33);
      start(4);
      wait_word(32'h33);
      tick();
      @(posedge clk);
      #1 abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      chk("abort_running", running, 0);
      chk("abort_error", error, 0);
      repeat (8) @(negedge clk);
      busy_len = 0;
      load(0, 32'h99);
      exp_instr.push_back(32'h99);
      exp_done.push_back(1'b0);
      start(1);
      wait_idle("post_abort");

      // Full-depth program: ends on the wrap at pc = DEPTH-1.
      for (int i = 0; i < 16; i++) load(i, W'(32'h100 + i));
      for (int i = 0; i < 16; i++) exp_instr.push_back(W'(32'h100 + i));
      exp_done.push_back(1'b0);
      start(16);
      wait_idle("wrap");

      // Asynchronous reset mid-EXEC.
      busy_len = 3;
      exp_instr.push_back(32'h100);
      exp_instr.push_back(32'h101);
      start(4);
      wait_word(32'h101);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk_all_zero("midreset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_reset_running", running, 0);

      chk("exp_instr_left", exp_instr.size(), 0);
      chk("exp_done_left", exp_done.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
